// File: rtl/lane_gene_collector_pkg.sv
// Shared definitions for the lane gene collector: state encodings, word sizes
// shared with the mutation lanes, and the bundle-mask popcount helper.
package lane_gene_collector_pkg;

    localparam int GENE_SZ = 64;
    localparam int ATTR_SZ = 8;

    typedef enum logic [1:0] {
        COLL_IDLE    = 2'b00,
        COLL_COLLECT = 2'b01,
        COLL_DRAIN   = 2'b10
    } coll_state_e;

    function automatic logic [1:0] popcount3(input logic [2:0] mask);
        return {1'b0, mask[0]} + {1'b0, mask[1]} + {1'b0, mask[2]};
    endfunction

endpackage

// File: rtl/lane_gene_fifo.sv
// Three-write / one-read gene FIFO. Set mask bits are packed into consecutive
// slots in mask order; the head word falls through to the output.
module lane_gene_fifo
    import lane_gene_collector_pkg::*;
#(
    parameter int GENE_SZ_P = GENE_SZ,
    parameter int DEPTH     = 8,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_wr_en,
    input  logic [2:0]           i_wr_mask,
    input  logic [GENE_SZ_P-1:0] i_gene1,
    input  logic [GENE_SZ_P-1:0] i_gene2,
    input  logic [GENE_SZ_P-1:0] i_gene3,
    input  logic                 i_pop,
    output logic [GENE_SZ_P-1:0] o_head,
    output logic                 o_valid,
    output logic [AW:0]          o_count
);

    logic [GENE_SZ_P-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    logic [GENE_SZ_P-1:0] w_slot [3];
    logic [1:0]           w_wr_num;
    logic                 w_pop;

    // Slot k receives the k-th set bit of the mask.
    always_comb begin
        w_slot[0] = i_wr_mask[0] ? i_gene1 : (i_wr_mask[1] ? i_gene2 : i_gene3);
        w_slot[1] = (i_wr_mask[0] && i_wr_mask[1]) ? i_gene2 : i_gene3;
        w_slot[2] = i_gene3;
    end

    assign w_wr_num = i_wr_en ? popcount3(i_wr_mask) : 2'd0;
    assign w_pop    = i_pop && (r_count != '0);

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (k < int'(w_wr_num)) begin
                r_mem[r_wr_ptr + AW'(k)] <= w_slot[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr_num);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_wr_num) - (AW+1)'(w_pop);
        end
    end

    assign o_valid = (r_count != '0);
    // Gated so the head reads zero out of reset without resetting storage.
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/lane_gene_collector.sv
// Lane gene collector top: genome framing FSM, input backpressure, emitted-gene
// counter and sticky error / done flags. LANE_COLLECT_COUNT_EN enables gene_count.
//
// state        | meaning
// COLL_IDLE    | no genome open; bundles dropped, waiting for start
// COLL_COLLECT | accepting bundles and emitting genes
// COLL_DRAIN   | input closed; emitting remaining genes until empty
module lane_gene_collector
    import lane_gene_collector_pkg::*;
#(
    parameter int GENE_SZ_P = GENE_SZ,
    parameter int ATTR_SZ_P = ATTR_SZ,
    parameter int DEPTH     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_done,
    input  logic [GENE_SZ_P-1:0] i_in_gene1,
    input  logic [GENE_SZ_P-1:0] i_in_gene2,
    input  logic [GENE_SZ_P-1:0] i_in_gene3,
    input  logic [2:0]           i_in_valid,
    output logic                 o_in_ready,
    output logic [GENE_SZ_P-1:0] o_out_gene,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [ATTR_SZ_P-1:0] o_gene_count,
    output logic                 o_genome_done,
    output logic                 o_overflow_err
);

    localparam int AW = $clog2(DEPTH);

    coll_state_e r_state;
    coll_state_e w_state_nxt;
    logic        r_genome_done;
    logic        r_overflow_err;
    logic        w_clear;
    logic        w_write;
    logic        w_drop;
    logic        w_pop;
    logic        w_drained;
    logic [AW:0] w_count;
    logic [AW:0] w_free;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= COLL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_drained   = 1'b0;
        case (r_state)
            COLL_IDLE: begin
                if (i_start) begin
                    w_state_nxt = COLL_COLLECT;
                    w_clear     = 1'b1;
                end
            end
            COLL_COLLECT: begin
                if (i_done) begin
                    w_state_nxt = COLL_DRAIN;
                end
            end
            COLL_DRAIN: begin
                if (w_count == '0) begin
                    w_state_nxt = COLL_IDLE;
                    w_drained   = 1'b1;
                end
            end
            default: w_state_nxt = COLL_IDLE;
        endcase
    end

    // Registered occupancy only: a pop in this same cycle is not credited.
    assign w_free     = (AW+1)'(DEPTH) - w_count;
    assign o_in_ready = (r_state == COLL_COLLECT) && (w_free >= (AW+1)'(3));
    assign w_write    = (i_in_valid != 3'b000) && o_in_ready;
    assign w_drop     = (r_state == COLL_COLLECT) && (i_in_valid != 3'b000) && !o_in_ready;
    assign w_pop      = o_out_valid && i_out_ready && (r_state != COLL_IDLE);

    lane_gene_fifo #(
        .GENE_SZ_P (GENE_SZ_P),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_clear),
        .i_wr_en   (w_write),
        .i_wr_mask (i_in_valid),
        .i_gene1   (i_in_gene1),
        .i_gene2   (i_in_gene2),
        .i_gene3   (i_in_gene3),
        .i_pop     (w_pop),
        .o_head    (o_out_gene),
        .o_valid   (o_out_valid),
        .o_count   (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_genome_done  <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            r_genome_done <= w_drained;
            if (w_clear) begin
                r_overflow_err <= 1'b0;
            end else if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    assign o_genome_done  = r_genome_done;
    assign o_overflow_err = r_overflow_err;

`ifdef LANE_COLLECT_COUNT_EN
    logic [ATTR_SZ_P-1:0] r_gene_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gene_count <= '0;
        end else if (w_clear) begin
            r_gene_count <= '0;
        end else if (w_pop && (r_gene_count != '1)) begin
            r_gene_count <= r_gene_count + ATTR_SZ_P'(1);
        end
    end

    assign o_gene_count = r_gene_count;
`else
    assign o_gene_count = '0;
`endif

endmodule

// File: doc/lane_gene_collector.md
# lane_gene_collector

Receiving end of the mutation-lane output interface. Accepts bundles of up to three genes per cycle (three gene words plus a 3-bit valid mask), compacts them in mask order (gene 1, gene 2, gene 3, skipping unset bits) into a small FIFO, and emits a single gene per cycle toward genome memory under a valid/ready handshake. Framing is per genome: `start` opens a genome, and `done` closes it once the buffer drains.

## Interface
- `GENE_SZ`, 64: gene word width.
- `ATTR_SZ`, 8: attribute/counter width.
- `DEPTH`, 8: FIFO entries; must be a power of 2 and ≥4.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: open a genome; IDLE only.
- `done` in 1: last bundle has been presented; COLLECT only.
- `in_gene1`/`in_gene2`/`in_gene3` in GENE_SZ: bundle words.
- `in_valid` in 3: bit k qualifies `in_gene(k+1)`.
- `in_ready` out 1: bundle will be accepted this cycle.
- `out_gene` out GENE_SZ: head gene.
- `out_valid` out 1: `out_gene` is valid.
- `out_ready` in 1: downstream accepts the head gene.
- `gene_count` out ATTR_SZ: genes emitted in the current genome.
- `genome_done` out 1: one-cycle pulse when a genome is fully drained.
- `overflow_err` out 1: sticky; a bundle was dropped.

## Operation
- States: IDLE, COLLECT, DRAIN. State encoding is 2 bits.
- **IDLE**
  - `start`=1 → COLLECT. Clears `gene_count`, `overflow_err` and the FIFO pointers.
  - `done` is ignored.
  - Bundles are dropped silently; `overflow_err` does not set.
- **COLLECT**
  - A write occurs when `in_valid`≠0 && `in_ready`.
  - The popcount(`in_valid`) genes are written in order gene1→gene2→gene3.
  - Writes then pops: writes go to consecutive slots; `wr_ptr` advances by the popcount, modulo DEPTH.
  - `in_valid`≠0 && !`in_ready` → the whole bundle is dropped (no partial write) and `overflow_err`←1.
  - `done` → DRAIN. A bundle presented in the same cycle as `done` is still accepted.
- **DRAIN**
  - Input is ignored.
  - When the FIFO is empty, go to IDLE and assert `genome_done` for exactly one cycle.
  - `done` with an empty FIFO gives a pulse one cycle after entering DRAIN.
- **Backpressure:** `in_ready` = (state==COLLECT) && (DEPTH − count ≥ 3). It depends on registered occupancy only; a same-cycle pop is not credited.
- **Output side**
  - `out_valid` = count≠0. `out_gene` = fifo[rd_ptr], first-word-fall-through.
  - A pop occurs when `out_valid` && `out_ready`; `rd_ptr`+1 modulo DEPTH.
  - Pops happen in both COLLECT and DRAIN.
- **Occupancy:** each cycle, count ← count + popcount(write) − pop, including simultaneous write and pop. count ranges 0..DEPTH; it uses log2(DEPTH)+1 bits.
- **`gene_count`:** +1 on every pop; saturates at 2^ATTR_SZ−1 (no wrap).
- `start` outside IDLE is ignored.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, count=0, pointers=0, `in_ready`=0, `out_valid`=0, `out_gene`=0, `gene_count`=0, `genome_done`=0, `overflow_err`=0.
- Write-to-output latency: a gene written at edge N is visible on `out_gene` after edge N (next cycle) if it is at the head.
- Throughput: up to 3 genes in and 1 gene out per cycle.
- `genome_done` is registered. It is high for the cycle after the edge on which DRAIN sees count==0.
- Reset mid-genome discards all buffered genes and produces no `genome_done`.

## Configuration
- `LANE_COLLECT_COUNT_EN`
  - Defined: the `gene_count` counter is implemented as above.
  - Undefined: no counter register; `gene_count` is tied to 0. All other behaviour is unchanged.

## Structure
- Shared include/package holds:
  - state encodings `COLL_IDLE`=2'b00, `COLL_COLLECT`=2'b01, `COLL_DRAIN`=2'b10;
  - a `popcount3` function;
  - the `GENE_SZ`/`ATTR_SZ` defaults shared with the mutation lanes.
- Sub-module `lane_gene_fifo`: 3-write/1-read FIFO with compaction, pointers and count.
- The top level holds the FSM, `in_ready`, the counter and the error/done flags.

## Test plan
- **Reset and open:** reset, then `start`, then in_valid=3'b111 with genes A,B,C and `out_ready`=1. Expect A,B,C on consecutive cycles starting one cycle after the write, and `gene_count`=3.
- **Sparse mask:** in_valid=3'b101 with genes A,B,C. Expect only A then C; B is never output.
- **Backpressure:** `out_ready`=0; write 3+3 genes (count=6, DEPTH=8). Expect `in_ready`=0. A further 3'b001 bundle is dropped and `overflow_err`=1, and it stays 1 until the next `start`.
- **Drain with stall:** `done` with 4 genes buffered, then `out_ready` toggling 1,0,1,0… Expect all 4 genes in order, then exactly one `genome_done` pulse, then IDLE.
- **Empty genome and wrap:**
  - `start`, then immediately `done`: `genome_done` pulses; `out_valid` is never asserted.
  - Separately, stream 20 genes at 3/cycle against 1/cycle pops: order is preserved across pointer wrap.
- **Async reset mid-DRAIN:** assert `rst`=0 with 5 genes buffered. Expect `out_valid`=0 immediately and all outputs at their reset values, with no `genome_done`.
